// File: rtl/data_mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_resp_pkg
// Shared definitions for the CPU data-memory responder:
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - legal byte-lane select patterns (bytes, halfwords, full word)
//   - data bus / memory depth widths shared with the core
//   - sel_is_legal(): membership test against the legal select set
// -----------------------------------------------------------------------------
package data_mem_resp_pkg;

  // Width of the CPU data bus and default number of words in data memory.
  localparam int DATA_BUS_W   = 32;
  localparam int DATA_MEM_NUM = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Little-endian byte lanes: bit 0 selects data[7:0].
  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

  function automatic logic sel_is_legal(input logic [3:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3,
      SEL_H0, SEL_H1, SEL_W: ok = 1'b1;
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_resp_ram.sv
// -----------------------------------------------------------------------------
// data_ram_bank
// Single-port synchronous RAM, 2^ADDR_W x 32, with four byte-write enables.
// Read data is registered; a read and a write to the same word in the same
// cycle returns the old contents (write-first behaviour is not provided).
// Contents are never cleared.
//
// Ports:
//   clk      in   clock
//   i_addr   in   ADDR_W  word address
//   i_be     in   4       byte-write enables (bit 0 -> bits 7:0)
//   i_wdata  in   32      write data, lane aligned
//   o_rdata  out  32      registered read data
// -----------------------------------------------------------------------------
module data_ram_bank
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [3:0]            i_be,
  input  logic [DATA_BUS_W-1:0] i_wdata,
  output logic [DATA_BUS_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_BUS_W-1:0] r_mem [DEPTH];
  logic [DATA_BUS_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_be[k]) begin
        r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Responder for the CPU data-memory port. Accepts one request at a time,
// inserts WAIT_STATES extra busy cycles, performs the access on a byte-lane
// RAM and pulses ack_o for one cycle. stallreq_o holds the pipeline from the
// request cycle until the completion cycle. Illegal requests (bad lane select
// or address beyond the RAM) run the same handshake but never write, return
// zero data and flag err_o.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   ce_i        in   access request
//   we_i        in   1 = store, 0 = load
//   addr_i      in   32  byte address
//   sel_i       in   4   byte-lane enables, little endian
//   data_i      in   32  store data, lane aligned
//   data_o      out  32  load data (held until the next load completion)
//   stallreq_o  out  stall request to the pipeline
//   ack_o       out  one-cycle completion pulse
//   err_o       out  completion was an illegal access (valid with ack_o)
// -----------------------------------------------------------------------------
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [3:0]            sel_i,
  input  logic [DATA_BUS_W-1:0] data_i,
  output logic [DATA_BUS_W-1:0] data_o,
  output logic                  stallreq_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

  state_e                r_state;
  state_e                w_next;
  logic [2:0]            r_cnt;

  // Request captured in IDLE; later changes on the inputs are ignored.
  logic                  r_we;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_waddr;
  logic [3:0]            r_sel;
  logic [DATA_BUS_W-1:0] r_wdata;

  logic [DATA_BUS_W-1:0] r_data_o;

  logic                  w_legal;
  logic                  w_start;
  logic                  w_access;
  logic [ADDR_W-1:0]     w_ram_addr;
  logic [3:0]            w_ram_be;
  logic [DATA_BUS_W-1:0] w_rdata;
  logic                  w_unused_lsb;

  // Lane select must be one of the naturally sized patterns and the byte
  // address must fall inside the RAM.
  assign w_legal  = sel_is_legal(sel_i) && (addr_i[31:ADDR_W+2] == '0);
  assign w_start  = (r_state == ST_IDLE) && ce_i;
  assign w_access = (r_state == ST_BUSY) && (r_cnt == 3'd0);

  // The byte offset inside a word is carried entirely by sel_i.
  assign w_unused_lsb = ^addr_i[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (ce_i)     w_next = ST_BUSY;
      ST_BUSY: if (w_access) w_next = ST_DONE;
      ST_DONE:               w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  // Output logic. In IDLE the stall follows ce_i so the core halts in the
  // very cycle it issues the request.
  always_comb begin
    stallreq_o = 1'b0;
    ack_o      = 1'b0;
    err_o      = 1'b0;
    case (r_state)
      ST_IDLE: stallreq_o = ce_i;
      ST_BUSY: stallreq_o = 1'b1;
      ST_DONE: begin
        ack_o = 1'b1;
        err_o = r_err;
      end
      default: ;
    endcase
  end

  // Wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else if (w_start) begin
      r_cnt <= WS_INIT;
    end else if ((r_state == ST_BUSY) && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Request capture (data path, no reset).
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_we    <= we_i;
      r_err   <= ~w_legal;
      r_waddr <= addr_i[ADDR_W+1:2];
      r_sel   <= sel_i;
      r_wdata <= data_i;
    end
  end

  // The RAM is addressed from addr_i while idle so that its registered read
  // of the requested word is already available in the first BUSY cycle; the
  // word stays stable through BUSY since nothing else writes the RAM.
  assign w_ram_addr = (r_state == ST_IDLE) ? addr_i[ADDR_W+1:2] : r_waddr;
  assign w_ram_be   = (w_access && r_we && !r_err) ? r_sel : 4'b0000;

  data_ram_bank #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // Load data register: updated on load completion or forced to zero on an
  // illegal completion; legal stores leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_o <= '0;
    end else if (w_access) begin
      if (r_err) begin
        r_data_o <= '0;
      end else if (!r_we) begin
        r_data_o <= w_rdata;
      end
    end
  end

  assign data_o = r_data_o;

endmodule
